// File: rtl/uc_pkg.sv
// uc_pkg: shared state, opcode, ALU and mux encodings for the multicycle control unit
package uc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic       ADR_PC  = 1'b0;
  localparam logic       ADR_ALU = 1'b1;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    return op == OP_SW ? IMM_S : op == OP_BR ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/alu_deco_param.sv
// alu_deco_param: maps func3/func7 to an ALU code and flags ops the configured width lacks
module alu_deco_param
  import uc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  is_r_i,
  input  logic [2:0]            func3_i,
  input  logic                  func7_i,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic                  unsupported_o
);
  logic [3:0] code;
  // func7 only selects sub (R-type only) and sra (both classes)
  always_comb begin
    code = ALU_ADD;
    case (func3_i)
      3'b000:  code = (is_r_i && func7_i) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = func7_i ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
  end
  assign alu_ctrl_o    = code[ALU_CTRL_W-1:0];
  assign unsupported_o = (ALU_CTRL_W < 4) && !(code inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT});
endmodule

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: Moore control FSM sequencing a shared-ALU, shared-memory RV32I datapath
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int ALU_CTRL_W  = 3,
  parameter bit BRANCH_FULL = 1'b1,
  parameter bit MEM_WAIT    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            func3,
  input  logic                  func7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  memReady,
  output logic                  pcWrite,
  output logic                  adrSrc,
  output logic                  irWrite,
  output logic                  memWrite,
  output logic                  regWrite,
  output logic [1:0]            resultSrc,
  output logic [1:0]            aluSrcA,
  output logic [1:0]            aluSrcB,
  output logic [2:0]            immSrc,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  illegal,
  output logic [3:0]            state
);
  localparam logic [ALU_CTRL_W-1:0] CTL_ADD = ALU_ADD[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] CTL_SUB = ALU_SUB[ALU_CTRL_W-1:0];
  state_t state_q, state_d, cur, dec_next;
  logic illegal_q, rdy, br_ok, taken, alu_unsup;
  logic [ALU_CTRL_W-1:0] alu_dec;
  alu_deco_param #(.ALU_CTRL_W(ALU_CTRL_W)) u_deco (
    .is_r_i       (op == OP_R),
    .func3_i      (func3),
    .func7_i      (func7),
    .alu_ctrl_o   (alu_dec),
    .unsupported_o(alu_unsup)
  );
  // while reset is low the outputs follow FETCH, so a pending write is dropped at once
  assign cur   = rst_n ? state_q : S_FETCH;
  assign rdy   = MEM_WAIT ? memReady : 1'b1;
  assign br_ok = BRANCH_FULL ? !(func3 inside {3'b010, 3'b011}) : func3 == F3_BEQ;
  // func3[2:1] picks the flag, func3[0] inverts it (bne/bge/bgeu)
  assign taken = (func3[2] ? (func3[1] ? ltu : lt) : zero) ^ func3[0];
  assign dec_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                    op == OP_R   ? (alu_unsup ? S_TRAP : S_EXECR) :
                    op == OP_I   ? (alu_unsup ? S_TRAP : S_EXECI) :
                    op == OP_BR  ? (br_ok ? S_BRANCH : S_TRAP) :
                    op == OP_JAL ? S_JAL : S_TRAP;
  assign immSrc  = imm_sel(op);
  assign illegal = illegal_q;
  assign state   = state_q;
  // state register; the trap flag latches on entry to TRAP and clears only on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end
  // next state and Moore outputs per state, everything inactive unless named
  always_comb begin
    state_d    = cur;
    pcWrite    = 1'b0;
    adrSrc     = ADR_PC;
    irWrite    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    resultSrc  = RES_ALUOUT;
    aluSrcA    = SRCA_PC;
    aluSrcB    = SRCB_RS2;
    aluControl = CTL_ADD;
    case (cur)
      S_FETCH: begin
        aluSrcB   = SRCB_4;
        resultSrc = RES_ALURES;
        irWrite   = rdy & rst_n;
        pcWrite   = rdy & rst_n;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        state_d = dec_next;
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc  = ADR_ALU;
        state_d = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultSrc = RES_RDATA;
        regWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc   = ADR_ALU;
        memWrite = 1'b1;
        state_d  = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        aluSrcA    = SRCA_RS1;
        aluControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_IMM;
        aluControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA    = SRCA_RS1;
        aluControl = CTL_SUB;
        pcWrite    = taken;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_4;
        pcWrite = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase
  end
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: directed and random checking of two uc_multiciclo configurations against a behavioural model
module tb_uc_multiciclo;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
  typedef struct packed {
    logic       pcw, adr, irw, memw, regw;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic [3:0] st;
    logic       ill;
  } obs_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [2];
  logic [6:0] op [2];
  logic [2:0] f3 [2];
  logic f7 [2], zero [2], lt [2], ltu [2], mrdy [2];
  logic pcw_a, adr_a, irw_a, memw_a, regw_a, ill_a, pcw_b, adr_b, irw_b, memw_b, regw_b, ill_b;
  logic [1:0] rs_a, sa_a, sb_a, rs_b, sa_b, sb_b;
  logic [2:0] imm_a, imm_b, alu_a;
  logic [3:0] alu_b, st_a, st_b;
  obs_t o_a, o_b, ex, ac;
  int checks = 0, errors = 0, nx;
  int n_pc, n_ir, n_rw, n_mw;
  logic [3:0] alu_seen;
  bit chk_en = 1'b0;
  int m_state [2] = '{0, 0};
  bit m_ill [2] = '{1'b0, 1'b0};
  // instance a: 3-bit ALU, full branches, waits on memReady; instance b: 4-bit ALU, beq only, no wait
  uc_multiciclo #(.ALU_CTRL_W(3), .BRANCH_FULL(1'b1), .MEM_WAIT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .op(op[0]), .func3(f3[0]), .func7(f7[0]), .zero(zero[0]),
    .lt(lt[0]), .ltu(ltu[0]), .memReady(mrdy[0]), .pcWrite(pcw_a), .adrSrc(adr_a),
    .irWrite(irw_a), .memWrite(memw_a), .regWrite(regw_a), .resultSrc(rs_a), .aluSrcA(sa_a),
    .aluSrcB(sb_a), .immSrc(imm_a), .aluControl(alu_a), .illegal(ill_a), .state(st_a));
  uc_multiciclo #(.ALU_CTRL_W(4), .BRANCH_FULL(1'b0), .MEM_WAIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .op(op[1]), .func3(f3[1]), .func7(f7[1]), .zero(zero[1]),
    .lt(lt[1]), .ltu(ltu[1]), .memReady(mrdy[1]), .pcWrite(pcw_b), .adrSrc(adr_b),
    .irWrite(irw_b), .memWrite(memw_b), .regWrite(regw_b), .resultSrc(rs_b), .aluSrcA(sa_b),
    .aluSrcB(sb_b), .immSrc(imm_b), .aluControl(alu_b), .illegal(ill_b), .state(st_b));
  always_comb o_a = {pcw_a, adr_a, irw_a, memw_a, regw_a, rs_a, sa_a, sb_a, imm_a, 1'b0, alu_a, st_a, ill_a};
  always_comb o_b = {pcw_b, adr_b, irw_b, memw_b, regw_b, rs_b, sa_b, sb_b, imm_b, alu_b, st_b, ill_b};
  function automatic obs_t obs(input int k);
    return k == 0 ? o_a : o_b;
  endfunction
  function automatic logic [3:0] alu_code(input int k);
    case (f3[k])
      3'd0: return (op[k] == RT && f7[k]) ? 4'd1 : 4'd0;
      3'd1: return 4'd6;
      3'd2: return 4'd5;
      3'd3: return 4'd9;
      3'd4: return 4'd4;
      3'd5: return f7[k] ? 4'd8 : 4'd7;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction
  function automatic bit br_taken(input int k);
    case (f3[k])
      3'd0: return zero[k];
      3'd1: return !zero[k];
      3'd4: return lt[k];
      3'd5: return !lt[k];
      3'd6: return ltu[k];
      3'd7: return !ltu[k];
      default: return 1'b0;
    endcase
  endfunction
  function automatic int next_st(input int k);
    bit rdy = (k == 1) || mrdy[k];
    bit alu_ok = (k == 1) || (alu_code(k) inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5});
    bit br_ok = (k == 0) ? !(f3[k] inside {3'd2, 3'd3}) : f3[k] == 3'd0;
    if (!rst_n[k]) return 0;
    case (m_state[k])
      0: return rdy ? 1 : 0;
      1: begin
        if (op[k] == LW || op[k] == SW) return 2;
        if (op[k] == RT) return alu_ok ? 6 : 11;
        if (op[k] == IT) return alu_ok ? 7 : 11;
        if (op[k] == BR) return br_ok ? 9 : 11;
        if (op[k] == JL) return 10;
        return 11;
      end
      2: return op[k] == SW ? 5 : 3;
      3: return rdy ? 4 : 3;
      5: return rdy ? 0 : 5;
      6, 7, 10: return 8;
      4, 8, 9: return 0;
      default: return 11;
    endcase
  endfunction
  function automatic obs_t exp_out(input int k);
    obs_t e = '0;
    int s = rst_n[k] ? m_state[k] : 0;
    bit rdy = (k == 1) || mrdy[k];
    e.imm = op[k] == SW ? 3'd1 : op[k] == BR ? 3'd2 : op[k] == JL ? 3'd3 : 3'd0;
    e.st = 4'(m_state[k]);
    e.ill = m_ill[k];
    case (s)
      0: begin e.sb = 2; e.rs = 2; e.irw = rdy && rst_n[k]; e.pcw = rdy && rst_n[k]; end
      1: begin e.sa = 1; e.sb = 1; end
      2: begin e.sa = 2; e.sb = 1; end
      3: e.adr = 1;
      4: begin e.rs = 1; e.regw = 1; end
      5: begin e.adr = 1; e.memw = 1; end
      6: begin e.sa = 2; e.alu = alu_code(k); end
      7: begin e.sa = 2; e.sb = 1; e.alu = alu_code(k); end
      8: e.regw = 1;
      9: begin e.sa = 2; e.alu = 4'd1; e.pcw = br_taken(k); end
      10: begin e.sa = 1; e.sb = 2; e.pcw = 1; end
      default: ;
    endcase
    if (k == 0) e.alu[3] = 1'b0;
    return e;
  endfunction
  // model advances on the same edge as the DUTs, from the inputs held across that edge
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      nx = next_st(k);
      m_ill[k] = rst_n[k] && (m_ill[k] || nx == 11);
      m_state[k] = nx;
    end
  // every cycle, both instances against the model
  always @(negedge clk)
    if (chk_en)
      for (int k = 0; k < 2; k++) begin
        ex = exp_out(k);
        ac = obs(k);
        checks++;
        if (ac !== ex) begin
          errors++;
          $display("FAIL dut%0d outputs: got %h expected %h (model state %0d)", k, ac, ex, m_state[k]);
        end
      end
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ins(input int k, input logic [6:0] o, input logic [2:0] f, input logic f7v);
    op[k] = o;
    f3[k] = f;
    f7[k] = f7v;
  endtask
  task automatic run_seq(input int k, input string nm, input int n, input logic [47:0] seq, input logic [11:0] rv);
    obs_t t;
    n_pc = 0; n_ir = 0; n_rw = 0; n_mw = 0; alu_seen = 4'hF;
    for (int i = 0; i < n; i++) begin
      mrdy[k] = rv[11-i];
      @(negedge clk);
      t = obs(k);
      chk($sformatf("%s state[%0d]", nm, i), t.st, seq[47-4*i -: 4]);
      n_pc += t.pcw; n_ir += t.irw; n_rw += t.regw; n_mw += t.memw;
      if (t.st inside {4'd6, 4'd7, 4'd9}) alu_seen = t.alu;
      tick();
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; zero[k] = 1'b0; lt[k] = 1'b0; ltu[k] = 1'b0; mrdy[k] = 1'b1;
      set_ins(k, LW, 3'd2, 1'b0);
    end
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset state", st_a, 0);
    chk("reset enables", {pcw_a, irw_a, memw_a, regw_a}, 0);
    chk("reset illegal", ill_a, 0);
    tick();
    rst_n[0] = 1'b1;
    run_seq(0, "lw", 11, 48'h0001_2333_3400, 12'b0010_0000_1000);
    chk("lw pcWrite cycles", n_pc, 1);
    chk("lw irWrite cycles", n_ir, 1);
    chk("lw regWrite cycles", n_rw, 1);
    set_ins(0, RT, 3'd0, 1'b1);
    run_seq(0, "sub", 4, 48'h0168_0000_0000, 12'hFFF);
    chk("sub aluControl", alu_seen, 1);
    chk("sub regWrite cycles", n_rw, 1);
    set_ins(0, BR, 3'd1, 1'b0);
    zero[0] = 1'b0;
    run_seq(0, "bne taken", 3, 48'h0190_0000_0000, 12'hFFF);
    chk("bne taken pcWrite", n_pc, 2);
    chk("branch aluControl", alu_seen, 1);
    zero[0] = 1'b1;
    run_seq(0, "bne not taken", 3, 48'h0190_0000_0000, 12'hFFF);
    chk("bne not taken pcWrite", n_pc, 1);
    set_ins(0, BR, 3'd6, 1'b0);
    ltu[0] = 1'b1;
    run_seq(0, "bltu", 3, 48'h0190_0000_0000, 12'hFFF);
    chk("bltu taken pcWrite", n_pc, 2);
    set_ins(0, 7'b0110111, 3'd0, 1'b0);
    run_seq(0, "lui", 3, 48'h01B0_0000_0000, 12'hFFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("trap hold state[%0d]", i), st_a, 11);
      chk($sformatf("trap hold illegal[%0d]", i), ill_a, 1);
      chk($sformatf("trap hold enables[%0d]", i), {pcw_a, irw_a, memw_a, regw_a}, 0);
      tick();
    end
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    mrdy[0] = 1'b0;
    @(negedge clk);
    chk("trap reset state", st_a, 0);
    chk("trap reset illegal", ill_a, 0);
    tick();
    set_ins(0, IT, 3'd4, 1'b0);
    run_seq(0, "xori w3", 3, 48'h01B0_0000_0000, 12'hFFF);
    chk("xori w3 illegal", ill_a, 1);
    rst_n[0] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    set_ins(1, IT, 3'd4, 1'b0);
    run_seq(1, "xori w4", 4, 48'h0178_0000_0000, 12'h000);
    chk("xori w4 aluControl", alu_seen, 4);
    set_ins(1, LW, 3'd2, 1'b0);
    run_seq(1, "lw nowait", 5, 48'h0123_4000_0000, 12'h000);
    chk("lw nowait irWrite cycles", n_ir, 1);
    set_ins(1, BR, 3'd1, 1'b0);
    run_seq(1, "bne beq-only", 3, 48'h01B0_0000_0000, 12'h000);
    rst_n[1] = 1'b0;
    rst_n[0] = 1'b1;
    set_ins(0, SW, 3'd2, 1'b0);
    run_seq(0, "sw", 5, 48'h0125_5000_0000, 12'b1000_0000_0000);
    chk("sw memWrite cycles", n_mw, 2);
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("sw reset memWrite", memw_a, 0);
    chk("sw reset enables", {pcw_a, irw_a, regw_a}, 0);
    tick();
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("sw reset state", st_a, 0);
    tick();
    rst_n[1] = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_state[k] == 0 && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 7))
            0: op[k] = LW;
            1: op[k] = SW;
            2: op[k] = RT;
            3: op[k] = IT;
            4: op[k] = BR;
            5: op[k] = JL;
            6: op[k] = 7'($urandom_range(0, 127));
            default: op[k] = LW;
          endcase
          f3[k] = 3'($urandom_range(0, 7));
          f7[k] = 1'($urandom_range(0, 1));
        end
        zero[k] = 1'($urandom_range(0, 1));
        lt[k] = 1'($urandom_range(0, 1));
        ltu[k] = 1'($urandom_range(0, 1));
        mrdy[k] = $urandom_range(0, 9) < 6;
        rst_n[k] = !((m_state[k] == 11 && $urandom_range(0, 3) == 0) || $urandom_range(0, 63) == 0);
      end
      tick();
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
